// File: rtl/div_ratio_mon.sv
// div_ratio_mon: measures period/high time of a divided clock and flags lock, ratio match and timeout
//   clk_i, rst_n (async, active low), sig_i (divided clock under measurement)
//   period_o/high_o: last period and high-sample count; valid_o: update pulse
//   lock_o: stable period; match_o: locked at EXP_DIV; tmo_o: no rise within counter range
//   Define DIV_MON_SYNC_EN to pass sig_i through a two-flop synchronizer.
module div_ratio_mon #(
  parameter int CNT_W    = 8,
  parameter int LOCK_CNT = 4,
  parameter int EXP_DIV  = 7
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             sig_i,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             valid_o,
  output logic             lock_o,
  output logic             match_o,
  output logic             tmo_o
);
  typedef enum logic {IDLE, MEAS} state_t;
  localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] EXP = CNT_W'(EXP_DIV);
  localparam logic [3:0] LOCK_M1 = 4'(LOCK_CNT - 1);
  state_t state_q, state_d;
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d, hi_cnt_q, hi_cnt_d, period_q, period_d, high_q, high_d;
  logic [3:0] eq_q, eq_d;
  logic s, s_prev_q, s_prev_d, valid_q, valid_d, lock_q, lock_d, match_q, match_d, tmo_q, tmo_d;
  logic rise, meas, tmo, same;
`ifdef DIV_MON_SYNC_EN
  logic [1:0] sync_q, sync_d;
  assign sync_d = {sync_q[0], sig_i};
  assign s = sync_q[1];
  always_ff @(posedge clk_i or negedge rst_n)
    if (!rst_n) sync_q <= '0;
    else sync_q <= sync_d;
`else
  assign s = sig_i;
`endif
  always_comb begin
    s_prev_d  = s;
    rise      = s & ~s_prev_q;
    meas      = rise && state_q == MEAS;
    // a rise landing on the terminal count is still a valid measurement
    tmo       = state_q == MEAS && !rise && per_cnt_q == MAX;
    same      = per_cnt_q == period_q;
    state_d   = rise ? MEAS : tmo ? IDLE : state_q;
    per_cnt_d = rise ? CNT_W'(1) : state_q == MEAS ? per_cnt_q + 1'b1 : per_cnt_q;
    hi_cnt_d  = rise ? CNT_W'(s) : state_q == MEAS ? hi_cnt_q + CNT_W'(s) : hi_cnt_q;
    period_d  = meas ? per_cnt_q : period_q;
    high_d    = meas ? hi_cnt_q : high_q;
    valid_d   = meas;
    tmo_d     = tmo;
    // equality count saturates so a long locked run keeps lock asserted
    eq_d      = tmo ? 4'd0 : meas ? (same ? (eq_q == LOCK_M1 ? eq_q : eq_q + 4'd1) : 4'd0) : eq_q;
    lock_d    = tmo ? 1'b0 : meas ? eq_d == LOCK_M1 : lock_q;
    match_d   = tmo ? 1'b0 : meas ? (eq_d == LOCK_M1 && per_cnt_q == EXP) : match_q;
  end
  always_ff @(posedge clk_i or negedge rst_n)
    if (!rst_n) begin
      state_q   <= IDLE;
      s_prev_q  <= 1'b0;
      per_cnt_q <= '0;
      hi_cnt_q  <= '0;
      period_q  <= '0;
      high_q    <= '0;
      eq_q      <= '0;
      valid_q   <= 1'b0;
      lock_q    <= 1'b0;
      match_q   <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_prev_q  <= s_prev_d;
      per_cnt_q <= per_cnt_d;
      hi_cnt_q  <= hi_cnt_d;
      period_q  <= period_d;
      high_q    <= high_d;
      eq_q      <= eq_d;
      valid_q   <= valid_d;
      lock_q    <= lock_d;
      match_q   <= match_d;
      tmo_q     <= tmo_d;
    end
  assign period_o = period_q;
  assign high_o   = high_q;
  assign valid_o  = valid_q;
  assign lock_o   = lock_q;
  assign match_o  = match_q;
  assign tmo_o    = tmo_q;
endmodule

// File: tb/tb_div_ratio_mon.sv
// tb_div_ratio_mon: directed table-driven bench for div_ratio_mon
module tb_div_ratio_mon;
`ifdef DIV_MON_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  typedef struct {
    int h; int l; bit v; int p; int hi; bit lk; bit mt;
  } vec_t;
  logic clk_i = 1'b0, rst_n = 1'b0, sig_i = 1'b0;
  logic [7:0] period_o, high_o;
  logic valid_o, lock_o, match_o, tmo_o;
  int n_cmp = 0, n_bad = 0, tmo_cnt = 0, valid_cnt = 0;
  vec_t tbl[17];
  div_ratio_mon #(.CNT_W(8), .LOCK_CNT(4), .EXP_DIV(7)) dut (
    .clk_i(clk_i), .rst_n(rst_n), .sig_i(sig_i), .period_o(period_o), .high_o(high_o),
    .valid_o(valid_o), .lock_o(lock_o), .match_o(match_o), .tmo_o(tmo_o)
  );
  always #5 clk_i = ~clk_i;
  always @(negedge clk_i) begin
    if (tmo_o) tmo_cnt++;
    if (valid_o) valid_cnt++;
  end
  task automatic cmp(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic cyc(input logic v);
    sig_i = v;
    @(posedge clk_i);
    #1;
  endtask
  // one period of h high / l low; the rise at its start reports the previous period
  task automatic apply(input string tag, input int h, input int l, input bit v, input int p,
                       input int hi, input bit lk, input bit mt);
    for (int i = 0; i < h + l; i++) begin
      cyc(i < h);
      if (i == LAT) begin
        cmp({tag, ".valid"}, valid_o, v);
        cmp({tag, ".period"}, period_o, p);
        cmp({tag, ".high"}, high_o, hi);
        cmp({tag, ".lock"}, lock_o, lk);
        cmp({tag, ".match"}, match_o, mt);
        cmp({tag, ".tmo"}, tmo_o, 0);
      end
      if (i == LAT + 1) cmp({tag, ".valid_end"}, valid_o, 0);
    end
  endtask
  initial begin
    int first, vc, tc;
    tbl[0]  = '{4, 3, 0, 0, 0, 0, 0};
    tbl[1]  = '{4, 3, 1, 7, 4, 0, 0};
    tbl[2]  = '{4, 3, 1, 7, 4, 0, 0};
    tbl[3]  = '{4, 3, 1, 7, 4, 0, 0};
    tbl[4]  = '{4, 3, 1, 7, 4, 1, 1};
    tbl[5]  = '{4, 4, 1, 7, 4, 1, 1};
    tbl[6]  = '{4, 3, 1, 8, 4, 0, 0};
    tbl[7]  = '{4, 3, 1, 7, 4, 0, 0};
    tbl[8]  = '{4, 3, 1, 7, 4, 0, 0};
    tbl[9]  = '{4, 3, 1, 7, 4, 0, 0};
    tbl[10] = '{4, 3, 1, 7, 4, 1, 1};
    tbl[11] = '{3, 2, 1, 7, 4, 1, 1};
    tbl[12] = '{3, 2, 1, 5, 3, 0, 0};
    tbl[13] = '{3, 2, 1, 5, 3, 0, 0};
    tbl[14] = '{3, 2, 1, 5, 3, 0, 0};
    tbl[15] = '{3, 2, 1, 5, 3, 1, 0};
    tbl[16] = '{3, 2, 1, 5, 3, 1, 0};
    repeat (3) cyc(0);
    cmp("rst.period", period_o, 0);
    cmp("rst.high", high_o, 0);
    cmp("rst.valid", valid_o, 0);
    cmp("rst.lock", lock_o, 0);
    cmp("rst.match", match_o, 0);
    cmp("rst.tmo", tmo_o, 0);
    rst_n = 1'b1;
    repeat (3) cyc(0);
    for (int k = 0; k < 17; k++)
      apply($sformatf("vec%0d", k), tbl[k].h, tbl[k].l, tbl[k].v, tbl[k].p, tbl[k].hi, tbl[k].lk, tbl[k].mt);
    first = -1;
    vc = valid_cnt;
    for (int j = 0; j < 300; j++) begin
      cyc(0);
      if (tmo_o && first < 0) first = j;
    end
    cmp("tmo.when", first, 250 + LAT);
    cmp("tmo.pulses", tmo_cnt, 1);
    cmp("tmo.no_valid", valid_cnt, vc);
    cmp("tmo.lock", lock_o, 0);
    cmp("tmo.match", match_o, 0);
    cmp("tmo.period", period_o, 5);
    cmp("tmo.high", high_o, 3);
    apply("post_tmo0", 4, 3, 0, 5, 3, 0, 0);
    apply("post_tmo1", 4, 3, 1, 7, 4, 0, 0);
    apply("edge255a", 1, 254, 1, 7, 4, 0, 0);
    apply("edge255b", 4, 3, 1, 255, 1, 0, 0);
    cmp("edge255.no_tmo", tmo_cnt, 1);
    apply("relock0", 4, 3, 1, 7, 4, 0, 0);
    apply("relock1", 4, 3, 1, 7, 4, 0, 0);
    apply("relock2", 4, 3, 1, 7, 4, 0, 0);
    apply("relock3", 4, 3, 1, 7, 4, 1, 1);
    cyc(1);
    cyc(1);
    #2 rst_n = 1'b0;
    #1;
    cmp("arst.period", period_o, 0);
    cmp("arst.high", high_o, 0);
    cmp("arst.valid", valid_o, 0);
    cmp("arst.lock", lock_o, 0);
    cmp("arst.match", match_o, 0);
    cmp("arst.tmo", tmo_o, 0);
    repeat (2) cyc(0);
    rst_n = 1'b1;
    repeat (3) cyc(0);
    tc = tmo_cnt;
    apply("after_rst0", 4, 3, 0, 0, 0, 0, 0);
    apply("after_rst1", 4, 3, 1, 7, 4, 0, 0);
    apply("after_rst2", 4, 3, 1, 7, 4, 0, 0);
    cmp("after_rst.no_tmo", tmo_cnt, tc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
